// File: rtl/mmram_match_join.sv
// Matching-memory data stage: stores waiting operands, joins them on a fire, passes others through.
// Optional even parity on stored words is enabled by defining MMRAM_PARITY_EN.
module mmram_match_join #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 16,
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6,
  parameter int OFD    = 4
) (
  input  logic              CP,
  input  logic              MR,
  input  logic              IN_VALID,
  output logic              IN_READY,
  input  logic [TAG_W-1:0]  IN_TAG,
  input  logic [DATA_W-1:0] IN_DATA,
  input  logic              IN_LR,
  input  logic              MATCH,
  input  logic              WR_E,
  input  logic [ADDR_W-1:0] ADDR,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output logic [TAG_W-1:0]  OUT_TAG,
  output logic [DATA_W-1:0] OUT_L,
  output logic [DATA_W-1:0] OUT_R,
  output logic              OUT_PAIR,
  output logic [ADDR_W:0]   OCC,
  output logic              ERR_OVF,
  output logic              ERR_LR,
  output logic              PERR
);
  localparam int PW = (OFD > 1) ? $clog2(OFD) : 1;
  localparam int CW = $clog2(OFD + 1);
  localparam int EW = TAG_W + 2 * DATA_W + 1;
`ifdef MMRAM_PARITY_EN
  localparam int WW = DATA_W + 2;
`else
  localparam int WW = DATA_W + 1;
`endif

  typedef enum logic [1:0] {OP_PASS, OP_STORE, OP_FIRE} op_e;

  logic              s1_v_q, s1_v_d, s1_lr_q, s1_lr_d;
  logic [TAG_W-1:0]  s1_tag_q, s1_tag_d;
  logic [DATA_W-1:0] s1_data_q, s1_data_d;
  logic              s2_v_q, s2_v_d, s2_lr_q, s2_lr_d, s2_fire_q, s2_fire_d;
  logic [TAG_W-1:0]  s2_tag_q, s2_tag_d;
  logic [DATA_W-1:0] s2_data_q, s2_data_d;
  logic [ADDR_W:0]   occ_q, occ_d;
  logic              err_ovf_q, err_ovf_d, err_lr_q, err_lr_d, perr_q, perr_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [WW-1:0]     rd_word_q;
  logic [WW-1:0]     ram_q [DEPTH];
  logic [EW-1:0]     fifo_q [OFD];

  op_e               op;
  logic              in_acc, ram_we, ram_re, push, pop, st_lr, out_pair;
  logic [WW-1:0]     wr_word;
  logic [DATA_W-1:0] st_data, out_l, out_r;
  logic [EW-1:0]     push_ent, head;
  logic [CW:0]       inflight;

  // S1/S2 never stall, so admission counts every packet that will land in the FIFO
  assign inflight = {1'b0, cnt_q} + (CW+1)'(s1_v_q) + (CW+1)'(s2_v_q);
  assign IN_READY = inflight < (CW+1)'(OFD);
  assign in_acc   = IN_VALID & IN_READY;

`ifdef MMRAM_PARITY_EN
  assign wr_word = {^{s1_data_q, s1_lr_q}, s1_data_q, s1_lr_q};
`else
  assign wr_word = {s1_data_q, s1_lr_q};
`endif

  assign st_data = rd_word_q[DATA_W:1];
  assign st_lr   = rd_word_q[0];

  always_comb begin
    op = OP_PASS;
    if (MATCH) op = WR_E ? OP_STORE : OP_FIRE;

    s1_v_d    = in_acc;
    s1_tag_d  = in_acc ? IN_TAG  : s1_tag_q;
    s1_data_d = in_acc ? IN_DATA : s1_data_q;
    s1_lr_d   = in_acc ? IN_LR   : s1_lr_q;

    s2_v_d    = s1_v_q && (op != OP_STORE);
    s2_fire_d = s1_v_q && (op == OP_FIRE);
    s2_tag_d  = s1_v_q ? s1_tag_q  : s2_tag_q;
    s2_data_d = s1_v_q ? s1_data_q : s2_data_q;
    s2_lr_d   = s1_v_q ? s1_lr_q   : s2_lr_q;

    occ_d     = occ_q;
    err_ovf_d = err_ovf_q;
    ram_we    = 1'b0;
    ram_re    = s1_v_q && (op == OP_FIRE);
    if (s1_v_q && op == OP_STORE) begin
      if (occ_q == (ADDR_W+1)'(DEPTH)) err_ovf_d = 1'b1;
      else begin
        ram_we = 1'b1;
        occ_d  = occ_q + (ADDR_W+1)'(1);
      end
    end else if (ram_re && occ_q != '0) begin
      occ_d = occ_q - (ADDR_W+1)'(1);
    end

    // Same-side pair falls to the else branch: incoming is L, stored is R
    out_l    = s2_data_q;
    out_r    = '0;
    out_pair = 1'b0;
    if (s2_fire_q) begin
      out_pair = 1'b1;
      if (s2_lr_q && !st_lr) begin
        out_l = st_data;
        out_r = s2_data_q;
      end else begin
        out_r = st_data;
      end
    end
    push     = s2_v_q;
    push_ent = {s2_tag_q, out_l, out_r, out_pair};

    err_lr_d = err_lr_q | (s2_v_q & s2_fire_q & (s2_lr_q == st_lr));
    perr_d   = perr_q;
`ifdef MMRAM_PARITY_EN
    if (s2_v_q && s2_fire_q && (^rd_word_q)) perr_d = 1'b1;
`endif

    pop      = (cnt_q != '0) && OUT_READY;
    cnt_d    = cnt_q + CW'(push) - CW'(pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = (wr_ptr_q == PW'(OFD - 1)) ? '0 : wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = (rd_ptr_q == PW'(OFD - 1)) ? '0 : rd_ptr_q + PW'(1);
  end

  always_ff @(posedge CP) begin
    if (MR) begin
      s1_v_q <= 1'b0; s1_tag_q <= '0; s1_data_q <= '0; s1_lr_q <= 1'b0;
      s2_v_q <= 1'b0; s2_tag_q <= '0; s2_data_q <= '0; s2_lr_q <= 1'b0;
      s2_fire_q <= 1'b0;
      occ_q <= '0; err_ovf_q <= 1'b0; err_lr_q <= 1'b0; perr_q <= 1'b0;
      wr_ptr_q <= '0; rd_ptr_q <= '0; cnt_q <= '0;
    end else begin
      s1_v_q <= s1_v_d; s1_tag_q <= s1_tag_d; s1_data_q <= s1_data_d; s1_lr_q <= s1_lr_d;
      s2_v_q <= s2_v_d; s2_tag_q <= s2_tag_d; s2_data_q <= s2_data_d; s2_lr_q <= s2_lr_d;
      s2_fire_q <= s2_fire_d;
      occ_q <= occ_d; err_ovf_q <= err_ovf_d; err_lr_q <= err_lr_d; perr_q <= perr_d;
      wr_ptr_q <= wr_ptr_d; rd_ptr_q <= rd_ptr_d; cnt_q <= cnt_d;
    end
  end

  // Storage arrays are not reset; RAM contents survive MR
  always_ff @(posedge CP) begin
    if (ram_we) ram_q[ADDR] <= wr_word;
    if (ram_re) rd_word_q <= ram_q[ADDR];
    if (push && !MR) fifo_q[wr_ptr_q] <= push_ent;
  end

  assign OUT_VALID = (cnt_q != '0);
  assign head      = OUT_VALID ? fifo_q[rd_ptr_q] : '0;
  assign OUT_TAG   = head[EW-1 -: TAG_W];
  assign OUT_L     = head[2*DATA_W:DATA_W+1];
  assign OUT_R     = head[DATA_W:1];
  assign OUT_PAIR  = head[0];
  assign OCC       = occ_q;
  assign ERR_OVF   = err_ovf_q;
  assign ERR_LR    = err_lr_q;
  assign PERR      = perr_q;
endmodule

// File: tb/tb_mmram_match_join.sv
// Directed bench for mmram_match_join: pass, pair, reverse, same-side, backpressure, overflow, reset, parity.
module tb_mmram_match_join;
  logic        CP = 1'b0, MR = 1'b1;
  logic        IN_VALID = 1'b0, IN_READY, IN_LR = 1'b0;
  logic [15:0] IN_TAG = '0;
  logic [31:0] IN_DATA = '0;
  logic        MATCH = 1'b0, WR_E = 1'b0;
  logic [5:0]  ADDR = '0;
  logic        OUT_VALID, OUT_READY = 1'b1, OUT_PAIR;
  logic [15:0] OUT_TAG;
  logic [31:0] OUT_L, OUT_R;
  logic [6:0]  OCC;
  logic        ERR_OVF, ERR_LR, PERR;

  int n_chk = 0, n_pass = 0;

  typedef struct packed {
    logic [15:0] tag;
    logic [31:0] l;
    logic [31:0] r;
    logic        p;
  } out_t;
  out_t got_q[$];

  mmram_match_join dut (
    .CP(CP), .MR(MR), .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN_TAG(IN_TAG),
    .IN_DATA(IN_DATA), .IN_LR(IN_LR), .MATCH(MATCH), .WR_E(WR_E), .ADDR(ADDR),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_TAG(OUT_TAG), .OUT_L(OUT_L),
    .OUT_R(OUT_R), .OUT_PAIR(OUT_PAIR), .OCC(OCC), .ERR_OVF(ERR_OVF), .ERR_LR(ERR_LR),
    .PERR(PERR)
  );

  always #5 CP = ~CP;

  // A head seen at the falling edge with OUT_READY high leaves on the next rising edge
  always @(negedge CP) begin
    if (OUT_VALID && OUT_READY && !MR) got_q.push_back(out_t'({OUT_TAG, OUT_L, OUT_R, OUT_PAIR}));
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  // MMCAM decision is presented right after the accepting edge, as that stage registers it
  task automatic send(input logic [15:0] tag, input logic [31:0] data, input logic lr,
                      input logic m, input logic w, input logic [5:0] a);
    int n = 0;
    @(negedge CP);
    IN_VALID = 1'b1; IN_TAG = tag; IN_DATA = data; IN_LR = lr;
    while (!IN_READY && n < 100) begin @(negedge CP); n++; end
    if (n >= 100) chk("send_timeout", 64'd0, 64'd1);
    @(posedge CP); #1;
    IN_VALID = 1'b0; MATCH = m; WR_E = w; ADDR = a;
  endtask

  task automatic get_out(input string nm, input logic [15:0] tag, input logic [31:0] l,
                         input logic [31:0] r, input logic p);
    int n = 0;
    out_t e;
    while (got_q.size() == 0 && n < 50) begin @(negedge CP); n++; end
    if (got_q.size() == 0) begin
      chk({nm, "_timeout"}, 64'd0, 64'd1);
    end else begin
      e = got_q.pop_front();
      chk({nm, "_tag"}, 64'(e.tag), 64'(tag));
      chk({nm, "_l"},   64'(e.l),   64'(l));
      chk({nm, "_r"},   64'(e.r),   64'(r));
      chk({nm, "_pair"}, 64'(e.p),  64'(p));
    end
  endtask

  task automatic tick;
    @(posedge CP); #1;
  endtask

  initial begin
    repeat (2) tick();
    MR = 1'b0;
    chk("rst_out_valid", 64'(OUT_VALID), 64'd0);
    chk("rst_in_ready",  64'(IN_READY),  64'd1);
    chk("rst_occ",       64'(OCC),       64'd0);
    chk("rst_flags",     64'({ERR_OVF, ERR_LR, PERR}), 64'd0);
    chk("rst_out_l",     64'(OUT_L),     64'd0);

    // pass-through with exact latency
    send(16'h0011, 32'hA5, 1'b0, 1'b0, 1'b0, 6'd0);
    tick();
    chk("pass_early", 64'(OUT_VALID), 64'd0);
    tick();
    chk("pass_valid", 64'(OUT_VALID), 64'd1);
    chk("pass_tag",   64'(OUT_TAG),   64'h0011);
    chk("pass_l",     64'(OUT_L),     64'hA5);
    chk("pass_r",     64'(OUT_R),     64'd0);
    chk("pass_pair",  64'(OUT_PAIR),  64'd0);
    chk("pass_occ",   64'(OCC),       64'd0);
    tick();
    got_q.delete();

    // store L then fire R at the same entry
    send(16'h0021, 32'd5, 1'b0, 1'b1, 1'b1, 6'd3);
    tick();
    chk("store_occ", 64'(OCC), 64'd1);
    repeat (2) tick();
    chk("store_no_out", 64'(OUT_VALID), 64'd0);
    send(16'h0022, 32'd7, 1'b1, 1'b1, 1'b0, 6'd3);
    get_out("pair", 16'h0022, 32'd5, 32'd7, 1'b1);
    chk("pair_occ", 64'(OCC), 64'd0);

    // reverse order at the top entry
    send(16'h0031, 32'd9, 1'b1, 1'b1, 1'b1, 6'd63);
    send(16'h0032, 32'd2, 1'b0, 1'b1, 1'b0, 6'd63);
    get_out("rev", 16'h0032, 32'd2, 32'd9, 1'b1);
    chk("rev_err_lr", 64'(ERR_LR), 64'd0);

    // same-side pair: incoming becomes L, stored becomes R
    send(16'h0041, 32'd1, 1'b0, 1'b1, 1'b1, 6'd10);
    send(16'h0042, 32'd4, 1'b0, 1'b1, 1'b0, 6'd10);
    get_out("same", 16'h0042, 32'd4, 32'd1, 1'b1);
    chk("same_err_lr", 64'(ERR_LR), 64'd1);

    // fire with nothing stored keeps OCC at zero
    send(16'h0051, 32'd0, 1'b0, 1'b1, 1'b0, 6'd20);
    tick();
    chk("underflow_occ", 64'(OCC), 64'd0);
    repeat (4) tick();
    got_q.delete();

    // backpressure: four in flight, then admission closes
    OUT_READY = 1'b0;
    for (int i = 0; i < 4; i++) send(16'(16'h0060 + i), 32'(32'h100 + i), 1'b0, 1'b0, 1'b0, 6'd0);
    @(negedge CP);
    chk("bp_ready_low", 64'(IN_READY), 64'd0);
    repeat (4) tick();
    chk("bp_ready_still_low", 64'(IN_READY), 64'd0);
    chk("bp_head_stable", 64'(OUT_TAG), 64'h0060);
    OUT_READY = 1'b1;
    for (int i = 4; i < 6; i++) send(16'(16'h0060 + i), 32'(32'h100 + i), 1'b0, 1'b0, 1'b0, 6'd0);
    for (int i = 0; i < 6; i++) get_out($sformatf("bp%0d", i), 16'(16'h0060 + i), 32'(32'h100 + i), 32'd0, 1'b0);

    // fill every entry, then one more store must be rejected
    for (int i = 0; i < 64; i++) send(16'(16'h0100 + i), 32'(i), 1'b0, 1'b1, 1'b1, 6'(i));
    tick();
    chk("full_occ", 64'(OCC), 64'd64);
    chk("full_no_ovf", 64'(ERR_OVF), 64'd0);
    send(16'h0200, 32'hDEAD, 1'b1, 1'b1, 1'b1, 6'd5);
    tick();
    chk("ovf_occ", 64'(OCC), 64'd64);
    chk("ovf_flag", 64'(ERR_OVF), 64'd1);
    send(16'h0201, 32'h77, 1'b1, 1'b1, 1'b0, 6'd5);
    get_out("ovf_kept", 16'h0201, 32'd5, 32'h77, 1'b1);

    // reset with a stuck output and packets in flight
    OUT_READY = 1'b0;
    send(16'h0071, 32'h33, 1'b0, 1'b0, 1'b0, 6'd0);
    send(16'h0072, 32'h44, 1'b0, 1'b1, 1'b1, 6'd7);
    send(16'h0073, 32'h55, 1'b0, 1'b0, 1'b0, 6'd0);
    tick();
    chk("pre_rst_valid", 64'(OUT_VALID), 64'd1);
    MR = 1'b1;
    tick();
    MR = 1'b0;
    chk("mr_out_valid", 64'(OUT_VALID), 64'd0);
    chk("mr_out_data", 64'({OUT_TAG, OUT_L}), 64'd0);
    chk("mr_occ", 64'(OCC), 64'd0);
    chk("mr_flags", 64'({ERR_OVF, ERR_LR, PERR}), 64'd0);
    chk("mr_in_ready", 64'(IN_READY), 64'd1);
    OUT_READY = 1'b1;
    repeat (5) tick();
    chk("mr_dropped", 64'(got_q.size()), 64'd0);

    // parity: corrupt a stored data bit before the fire
    send(16'h0081, 32'd5, 1'b0, 1'b1, 1'b1, 6'd3);
    tick();
`ifdef MMRAM_PARITY_EN
    dut.ram_q[3][1] = ~dut.ram_q[3][1];
    send(16'h0082, 32'd7, 1'b1, 1'b1, 1'b0, 6'd3);
    get_out("par", 16'h0082, 32'd4, 32'd7, 1'b1);
    tick();
    chk("perr_set", 64'(PERR), 64'd1);
`else
    send(16'h0082, 32'd7, 1'b1, 1'b1, 1'b0, 6'd3);
    get_out("par", 16'h0082, 32'd5, 32'd7, 1'b1);
    tick();
    chk("perr_zero", 64'(PERR), 64'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired after %0d checks", n_chk);
    $fatal(1);
  end
endmodule
